// File: rtl/agc_step_ctrl.sv
// Gain-step controller: times three detector intervals per frame, runs the
// threshold decision and steps the PGA select, holding off after each change.
module agc_step_ctrl #(
  parameter int          bit_width  = 22,
  parameter int          td         = 124420,
  parameter logic [3:0]  SEL_INIT   = 4'd15,
  parameter int          UP_CNT     = 4,
  parameter int          SETTLE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ori_a_mark,
  input  logic       ori_b_mark,
  input  logic       amp_mark,
  output logic [3:0] sel,
  output logic       sel_valid,
  output logic       amp_ok,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    MEAS_A,
    MEAS_B,
    MEAS_AMP,
    DECIDE,
    SETTLE
  } state_t;

  localparam logic [bit_width-1:0] CNT_MAX     = '1;
  localparam logic [bit_width-1:0] TD_W        = bit_width'(td);
  localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0]           UP_LAST     = 4'(UP_CNT - 1);

  state_t               state_reg;
  logic [bit_width-1:0] cnt_reg;
  logic [7:0]           settle_cnt_reg;
  logic [3:0]           ok_cnt_reg;
  logic [bit_width-1:0] t_a_reg;
  logic [bit_width-1:0] t_b_reg;
  logic [bit_width-1:0] t_amp_reg;
  logic                 to_flag_reg;

  logic [bit_width-1:0] cnt_inc;
  logic [bit_width-1:0] tmp;
  logic                 phase_mark;
  logic                 phase_done;
  logic                 ok;

  // cnt_inc is the cycle count in the current phase including this cycle; at
  // saturation it already equals all-ones, so it doubles as the latched value.
  always_comb begin
    cnt_inc    = cnt_reg + 1'b1;
    phase_mark = ((state_reg == MEAS_A)   && ori_a_mark) ||
                 ((state_reg == MEAS_B)   && ori_b_mark) ||
                 ((state_reg == MEAS_AMP) && amp_mark);
    phase_done = phase_mark || (cnt_inc == CNT_MAX);
    tmp        = t_a_reg + t_b_reg + TD_W;
    ok         = (tmp > t_amp_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      settle_cnt_reg <= '0;
      ok_cnt_reg     <= '0;
      t_a_reg        <= '0;
      t_b_reg        <= '0;
      t_amp_reg      <= '0;
      to_flag_reg    <= 1'b0;
      sel            <= SEL_INIT;
      sel_valid      <= 1'b0;
      amp_ok         <= 1'b0;
      timeout        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      sel_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= MEAS_A;
            cnt_reg     <= '0;
            timeout     <= 1'b0;
            to_flag_reg <= 1'b0;
            busy        <= 1'b1;
          end
        end

        MEAS_A: begin
          if (phase_done) begin
            t_a_reg     <= cnt_inc;
            cnt_reg     <= '0;
            to_flag_reg <= to_flag_reg | ~phase_mark;
            state_reg   <= MEAS_B;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        MEAS_B: begin
          if (phase_done) begin
            t_b_reg     <= cnt_inc;
            cnt_reg     <= '0;
            to_flag_reg <= to_flag_reg | ~phase_mark;
            state_reg   <= MEAS_AMP;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        MEAS_AMP: begin
          if (phase_done) begin
            t_amp_reg   <= cnt_inc;
            cnt_reg     <= '0;
            to_flag_reg <= to_flag_reg | ~phase_mark;
            state_reg   <= DECIDE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        DECIDE: begin
          sel_valid      <= 1'b1;
          amp_ok         <= ok;
          timeout        <= to_flag_reg;
          settle_cnt_reg <= '0;
          state_reg      <= IDLE;
          busy           <= 1'b0;
          if (to_flag_reg) begin
            ok_cnt_reg <= '0;
          end else if (!ok) begin
            ok_cnt_reg <= '0;
            if (sel != 4'd0) begin
              sel       <= sel - 4'd1;
              state_reg <= SETTLE;
              busy      <= 1'b1;
            end
          end else if (ok_cnt_reg == UP_LAST) begin
            ok_cnt_reg <= '0;
            if (sel != 4'd15) begin
              sel       <= sel + 4'd1;
              state_reg <= SETTLE;
              busy      <= 1'b1;
            end
          end else begin
            ok_cnt_reg <= ok_cnt_reg + 4'd1;
          end
        end

        SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 8'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_agc_step_ctrl.sv
// Directed bench for agc_step_ctrl with bit_width=8, td=10, UP_CNT=2,
// SETTLE_CYC=4, SEL_INIT=15.
module tb_agc_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ori_a_mark = 1'b0;
  logic       ori_b_mark = 1'b0;
  logic       amp_mark = 1'b0;
  logic [3:0] sel;
  logic       sel_valid;
  logic       amp_ok;
  logic       timeout;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  agc_step_ctrl #(
    .bit_width (8),
    .td        (10),
    .SEL_INIT  (4'd15),
    .UP_CNT    (2),
    .SETTLE_CYC(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ori_a_mark(ori_a_mark),
    .ori_b_mark(ori_b_mark),
    .amp_mark  (amp_mark),
    .sel       (sel),
    .sel_valid (sel_valid),
    .amp_ok    (amp_ok),
    .timeout   (timeout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse one mark so it is sampled on the n-th edge from now.
  task automatic mark_after(input int which, input int n);
    repeat (n - 1) @(negedge clk);
    case (which)
      0:       ori_a_mark = 1'b1;
      1:       ori_b_mark = 1'b1;
      default: amp_mark   = 1'b1;
    endcase
    @(negedge clk);
    ori_a_mark = 1'b0;
    ori_b_mark = 1'b0;
    amp_mark   = 1'b0;
  endtask

  task automatic begin_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_start", busy, 1);
  endtask

  // Ends on the negedge just after the DECIDE edge.
  task automatic run_frame(input int a, input int b, input int amp);
    begin_frame();
    mark_after(0, a);
    mark_after(1, b);
    mark_after(2, amp);
    check("valid_before_decide", sel_valid, 0);
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int exp_sel, input int exp_ok,
                              input int exp_to, input int exp_settle);
    int n;
    check({tag, "_sel"}, sel, exp_sel);
    check({tag, "_amp_ok"}, amp_ok, exp_ok);
    check({tag, "_timeout"}, timeout, exp_to);
    check({tag, "_valid"}, sel_valid, 1);
    check({tag, "_busy"}, busy, exp_settle);
    @(negedge clk);
    check({tag, "_valid_drop"}, sel_valid, 0);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_settle_len"}, n, (exp_settle != 0) ? 3 : 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sel", sel, 15);
    check("rst_busy", busy, 0);
    check("rst_valid", sel_valid, 0);
    check("rst_amp_ok", amp_ok, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;

    // tmp=20 not > 25: step down with settle
    run_frame(5, 5, 25);
    check_result("fail1", 14, 0, 0, 1);

    // Two passes: first holds, second steps up
    run_frame(5, 5, 12);
    check_result("pass1", 14, 1, 0, 0);
    run_frame(5, 5, 12);
    check_result("pass2", 15, 1, 0, 1);
    run_frame(5, 5, 12);
    check_result("pass3", 15, 1, 0, 0);

    // Wrap: 200+50+10 = 260 -> 4; second pass at 15 holds at ceiling
    run_frame(200, 50, 3);
    check_result("wrap_ok", 15, 1, 0, 0);
    run_frame(200, 50, 4);
    check_result("wrap_fail", 14, 0, 0, 1);

    // Drive to floor
    for (int i = 13; i >= 0; i--) begin
      run_frame(2, 2, 20);
      check_result("down", i, 0, 0, 1);
    end
    run_frame(2, 2, 20);
    check_result("floor", 0, 0, 0, 0);

    // ok_cnt becomes 1 here; the timeout frame must clear it
    run_frame(5, 5, 12);
    check_result("pre_to", 0, 1, 0, 0);

    // Timeout: no ori_b_mark; stray start/marks during MEAS_B are ignored
    begin_frame();
    mark_after(0, 5);
    repeat (10) @(negedge clk);
    start = 1'b1;
    ori_a_mark = 1'b1;
    amp_mark = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ori_a_mark = 1'b0;
    amp_mark = 1'b0;
    repeat (244) @(negedge clk);
    mark_after(2, 3);
    check("to_valid_before_decide", sel_valid, 0);
    @(negedge clk);
    check_result("timeout", 0, 1, 1, 0);

    // ok_cnt was cleared, so this pass must not step up; timeout clears
    run_frame(5, 5, 12);
    check_result("post_to", 0, 1, 0, 0);

    // Reset mid-MEAS_B
    begin_frame();
    mark_after(0, 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_sel", sel, 15);
    check("midrst_valid", sel_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(2, 2, 20);
    check_result("after_rst", 14, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/agc_step_ctrl.md
# agc_step_ctrl

Frame-level gain-step controller for the AGC loop. It times three interval marks from the detector front end: original-signal mark A, original-signal mark B, and amplified-signal mark. It then runs the threshold decision t_ori_a + t_ori_b + td > t_amp and steps the 4-bit gain select down on failure or up after a run of passes. It sits between the edge detectors and the PGA select register, and after every gain change it holds off new frames until the amplifier settles.

## Interface

Parameters:
- bit_width, 22, width of interval counters and decision arithmetic
- td, 124420, decision margin in clock cycles
- SEL_INIT, 4'd15, gain select value after reset
- UP_CNT, 4, consecutive passing frames required before a gain increment (1..15)
- SETTLE_CYC, 16, hold-off cycles after any select change (1..255)

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1, system clock; all state changes on the rising edge
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, single-cycle pulse that opens a measurement frame
- ori_a_mark, input, 1, single-cycle pulse that ends phase A
- ori_b_mark, input, 1, single-cycle pulse that ends phase B
- amp_mark, input, 1, single-cycle pulse that ends the amplified phase
- sel, output, 4, current gain select (registered)
- sel_valid, output, 1, one-cycle pulse after each decision
- amp_ok, output, 1, result of the last decision (registered)
- timeout, output, 1, the last frame had a saturated phase
- busy, output, 1, high in every state except IDLE

## Operation

- FSM states: IDLE, MEAS_A, MEAS_B, MEAS_AMP, DECIDE, SETTLE.
- IDLE: start → MEAS_A. On the same edge, clear the interval counter and the timeout output.
- MEAS_A, MEAS_B, MEAS_AMP:
  - One shared counter clears on state entry and increments every cycle.
  - Latched phase value = number of cycles spent in the state, including the mark cycle. A mark on the first cycle in the state latches 1.
  - MEAS_A ends on ori_a_mark (latches t_ori_a), MEAS_B ends on ori_b_mark (latches t_ori_b), MEAS_AMP ends on amp_mark (latches t_amp). Each goes to the next state.
  - A mark that belongs to a different state is ignored.
  - If the counter reaches 2^bit_width−1 with no mark: latch all-ones, set the internal timeout flag, advance as if the mark had arrived.
- DECIDE (one cycle):
  - tmp = t_ori_a + t_ori_b + td, truncated to bit_width (wraps modulo 2^bit_width, no saturation).
  - ok = (tmp > t_amp), unsigned compare.
  - If the timeout flag is set: sel unchanged, ok_cnt cleared, timeout output = 1, amp_ok = ok.
  - Else if !ok: ok_cnt cleared; sel decrements unless it is 0, where it holds.
  - Else (ok): ok_cnt increments. If ok_cnt reaches UP_CNT: ok_cnt clears, and sel increments unless it is 15, where it holds.
  - sel, amp_ok, timeout and sel_valid all register on the DECIDE edge.
  - Next state is SETTLE if sel changed, otherwise IDLE.
- SETTLE: counts SETTLE_CYC cycles, then → IDLE.
- start is ignored in every state except IDLE.
- Reset values:
  - sel = SEL_INIT; sel_valid, amp_ok, timeout, busy = 0.
  - ok_cnt and counter = 0; state = IDLE.
  - Reset mid-frame aborts the frame with no sel change.

## Timing

- start sampled at edge N → busy = 1 from N.
- Frame latency = t_ori_a + t_ori_b + t_amp + 1 (DECIDE) cycles, measured from the start edge to the sel update. SETTLE_CYC more cycles follow if sel changed.
- sel_valid is high exactly the one cycle after the DECIDE edge, while sel already shows the new value.
- A mark arriving on the same cycle as a saturation is treated as the mark: value latched is all-ones, and the timeout flag is not set.
- The earliest next start after a frame with no change is accepted on the cycle after sel_valid.

## Test plan

Bench overrides: bit_width=8, td=10, UP_CNT=2, SETTLE_CYC=4, SEL_INIT=15.

- Reset → sel=15, busy=0, sel_valid=0, amp_ok=0, timeout=0. Assert rst_n low mid-MEAS_B → busy=0 immediately, sel=15.
- Marks spaced A=5, B=5, amp=25 (tmp=20, not > 25) → amp_ok=0, sel 15→14, sel_valid one cycle, busy held 4 cycles (SETTLE), then IDLE.
- A=5, B=5, amp=12 twice in a row → first frame: amp_ok=1, sel unchanged, IDLE directly; second frame: sel 14→15. A third passing frame at sel=15 → sel holds 15 and there is no SETTLE.
- sel driven to 0 by repeated failing frames, then one more failing frame → sel stays 0, and busy returns low without SETTLE.
- Wrap check: A=200, B=50 (tmp=(260) mod 256=4), amp=3 → amp_ok=1. With amp=4 → amp_ok=0 and sel decrements.
- No ori_b_mark → MEAS_B saturates at 255; the frame completes with timeout=1, sel unchanged, ok_cnt cleared. A start pulse asserted during this frame is ignored.
